// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 make/break sequences (E0/F0 prefixes)
// into held flags for five game keys, per-player paddle directions and a
// one-cycle start pulse.
// Optional feature: define KEY_TRACKER_TIMEOUT_EN to force a release of all
// keys after TIMEOUT_CYCLES cycles with no received byte.
// Handshake: a byte on tasta is consumed on every rising clock edge where
// done=1; there is no back-pressure, so every strobe (including strobes on
// back-to-back cycles) is taken.
module ps2_key_tracker #(
  parameter logic [7:0] P1_UP_CODE   = 8'h1D,
  parameter logic [7:0] P1_DOWN_CODE = 8'h1B,
  parameter logic [7:0] P2_UP_CODE   = 8'h75,
  parameter logic [7:0] P2_DOWN_CODE = 8'h72,
  parameter logic [7:0] START_CODE   = 8'h29
`ifdef KEY_TRACKER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       done,
  input  logic [7:0] tasta,
  output logic [4:0] held,
  output logic [1:0] dir_1,
  output logic [1:0] dir_2,
  output logic       start_pulse,
  output logic       seq_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GOT_E0   = 2'd1;
  localparam logic [1:0] GOT_F0   = 2'd2;
  localparam logic [1:0] GOT_E0F0 = 2'd3;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FC = 8'hFC;

  logic [1:0] state_q, state_d;
  logic [4:0] held_q, held_d;
  logic       err_q, err_d;
  logic       pulse_q, pulse_d;
  logic       is_key, is_make, is_ext;
  logic [4:0] hit;

`ifdef KEY_TRACKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Prefix FSM: classify the incoming byte as prefix, BAT result or key event.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    is_key  = 1'b0;
    is_make = 1'b0;
    is_ext  = 1'b0;
    if (done) begin
      case (state_q)
        IDLE: begin
          if (tasta == BYTE_E0) state_d = GOT_E0;
          else if (tasta == BYTE_F0) state_d = GOT_F0;
          else if (tasta != BYTE_AA && tasta != BYTE_FC) begin
            is_key  = 1'b1;
            is_make = 1'b1;
          end
        end
        GOT_E0: begin
          if (tasta == BYTE_F0) state_d = GOT_E0F0;
          else if (tasta == BYTE_E0) err_d = 1'b1;
          else begin
            is_key  = 1'b1;
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          // GOT_F0 / GOT_E0F0: a second prefix here is malformed; restart on it.
          if (tasta == BYTE_E0) begin
            state_d = GOT_E0;
            err_d   = 1'b1;
          end else if (tasta == BYTE_F0) begin
            state_d = GOT_F0;
            err_d   = 1'b1;
          end else begin
            is_key  = 1'b1;
            is_ext  = (state_q == GOT_E0F0);
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Key match (code and extended flag) and the resulting held/pulse update.
  always_comb begin
    hit[0] = is_key && !is_ext && (tasta == P1_UP_CODE);
    hit[1] = is_key && !is_ext && (tasta == P1_DOWN_CODE);
    hit[2] = is_key &&  is_ext && (tasta == P2_UP_CODE);
    hit[3] = is_key &&  is_ext && (tasta == P2_DOWN_CODE);
    hit[4] = is_key && !is_ext && (tasta == START_CODE);
    held_d  = held_q;
    pulse_d = 1'b0;
    if (done && state_q == IDLE && (tasta == BYTE_AA || tasta == BYTE_FC)) begin
      held_d = 5'b0;
    end else if (is_key) begin
      held_d  = is_make ? (held_q | hit) : (held_q & ~hit);
      pulse_d = is_make && hit[4] && !held_q[4];
    end
`ifdef KEY_TRACKER_TIMEOUT_EN
    cnt_d = cnt_q;
    if (done) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      // Idle limit reached: assume a break code was lost and release all.
      cnt_d  = CNT_W'(TIMEOUT_CYCLES);
      held_d = 5'b0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // Register stage for FSM state, flags and the start pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      held_q  <= 5'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
`ifdef KEY_TRACKER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
`ifdef KEY_TRACKER_TIMEOUT_EN
      state_q <= (!done && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) ? IDLE : state_d;
      cnt_q   <= cnt_d;
`else
      state_q <= state_d;
`endif
      held_q  <= held_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  // Direction codes straight from the registered held bits.
  always_comb begin
    dir_1 = {held_q[0] & ~held_q[1], held_q[1] & ~held_q[0]};
    dir_2 = {held_q[2] & ~held_q[3], held_q[3] & ~held_q[2]};
  end

  assign held        = held_q;
  assign start_pulse = pulse_q;
  assign seq_err     = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed scenarios plus a random byte stream, all
// checked every cycle against a prefix-flag model of the key tracker.
module tb_ps2_key_tracker;

`ifdef KEY_TRACKER_TIMEOUT_EN
  localparam int TMO = 100;
`endif

  logic       clock;
  logic       rst;
  logic       done;
  logic [7:0] tasta;
  logic [4:0] held;
  logic [1:0] dir_1;
  logic [1:0] dir_2;
  logic       start_pulse;
  logic       seq_err;
  logic [1:0] state_dbg;

  int total;
  int bad;
  int pulse_cnt;

  // expected {seq_err, start_pulse, held} for each sampled edge
  logic [6:0] exp_q[$];

  // model state: pending prefixes, key flags, sticky error
  bit       m_ext;
  bit       m_brk;
  bit [4:0] m_held;
  bit       m_err;
  bit       m_pulse;
  int       m_idle;
  logic [7:0] codes [5];
  bit         ext_req [5];

`ifdef KEY_TRACKER_TIMEOUT_EN
  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  ps2_key_tracker dut (
`endif
    .clock(clock), .rst(rst), .done(done), .tasta(tasta), .held(held),
    .dir_1(dir_1), .dir_2(dir_2), .start_pulse(start_pulse),
    .seq_err(seq_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    codes[0] = 8'h1D; ext_req[0] = 1'b0;
    codes[1] = 8'h1B; ext_req[1] = 1'b0;
    codes[2] = 8'h75; ext_req[2] = 1'b1;
    codes[3] = 8'h72; ext_req[3] = 1'b1;
    codes[4] = 8'h29; ext_req[4] = 1'b0;
  end

  function automatic logic [1:0] dir_of(input bit up, input bit down);
    if (up && !down) return 2'b10;
    if (down && !up) return 2'b01;
    return 2'b00;
  endfunction

  // model: decode one byte from the prefix flags
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (m_ext || m_brk) m_err = 1'b1;
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      if (m_brk) begin
        m_err = 1'b1;
        m_ext = 1'b0;
      end
      m_brk = 1'b1;
    end else begin
      if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFC)) begin
        m_held = '0;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (codes[k] == b && ext_req[k] == m_ext) begin
            if (!m_brk) begin
              if (k == 4 && !m_held[4]) m_pulse = 1'b1;
              m_held[k] = 1'b1;
            end else begin
              m_held[k] = 1'b0;
            end
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // model update at each active edge
  always @(posedge clock) begin
    m_pulse = 1'b0;
    if (!rst) begin
      m_ext = 0; m_brk = 0; m_held = '0; m_err = 0; m_idle = 0;
    end else if (done) begin
      m_idle = 0;
      model_byte(tasta);
    end else begin
`ifdef KEY_TRACKER_TIMEOUT_EN
      if (m_idle < TMO) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_held = '0; m_ext = 0; m_brk = 0;
        end
      end
`endif
    end
    exp_q.push_back({m_err, m_pulse, m_held});
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // compare process: DUT vs model every cycle
  always @(posedge clock) begin
    logic [6:0] e;
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL exp_q_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("held", {3'b0, held}, {3'b0, e[4:0]});
      chk("start_pulse", {7'b0, start_pulse}, {7'b0, e[5]});
      chk("seq_err", {7'b0, seq_err}, {7'b0, e[6]});
      chk("dir_1", {6'b0, dir_1}, {6'b0, dir_of(e[0], e[1])});
      chk("dir_2", {6'b0, dir_2}, {6'b0, dir_of(e[2], e[3])});
      if (start_pulse === 1'b1) pulse_cnt++;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    done  = 1'b1;
    tasta = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      done  = 1'b0;
      tasta = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst  = 1'b0;
    done = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] pool [10];
    int r;
    total = 0; bad = 0; pulse_cnt = 0;
    rst = 1'b0; done = 1'b0; tasta = 8'h00;
    pool = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'hAA, 8'hFC, 8'h00};
    repeat (3) @(negedge clock);
    chk("reset_held", {3'b0, held}, 8'h00);
    chk("reset_err", {7'b0, seq_err}, 8'h00);
    chk("reset_dir", {4'b0, dir_1, dir_2}, 8'h00);
    rst = 1'b1;

    send_byte(8'h1D); idle(1);
    chk("p1_up_held", {3'b0, held}, 8'h01);
    chk("p1_up_dir", {6'b0, dir_1}, 8'h02);
    send_byte(8'hF0); send_byte(8'h1D); idle(1);
    chk("p1_up_break", {3'b0, held}, 8'h00);

    send_byte(8'hE0); send_byte(8'h75); idle(1);
    chk("p2_up_dir", {6'b0, dir_2}, 8'h02);
    send_byte(8'h75); idle(1);
    chk("keypad8_ignored", {3'b0, held}, 8'h04);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); idle(1);
    chk("p2_up_break", {3'b0, held}, 8'h00);

    pulse_cnt = 0;
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29); idle(2);
    chk("one_start_pulse", 8'(pulse_cnt), 8'd1);
    send_byte(8'hF0); send_byte(8'h29); send_byte(8'h29); idle(2);
    chk("second_start_pulse", 8'(pulse_cnt), 8'd2);
    send_byte(8'hF0); send_byte(8'h29); idle(1);

    send_byte(8'h1D); send_byte(8'h1B); idle(1);
    chk("both_held", {6'b0, held[1:0]}, 8'h03);
    chk("both_dir", {6'b0, dir_1}, 8'h00);
    send_byte(8'hF0); send_byte(8'h1D); idle(1);
    chk("p1_down_dir", {6'b0, dir_1}, 8'h01);
    send_byte(8'hF0); send_byte(8'h1B); idle(1);

    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75); idle(1);
    chk("bad_prefix_err", {7'b0, seq_err}, 8'h01);
    chk("bad_prefix_held", {3'b0, held}, 8'h04);
    send_byte(8'hAA); idle(1);
    chk("bat_clear", {3'b0, held}, 8'h00);

    send_byte(8'hE0); idle(1);
    do_reset();
    send_byte(8'h75); idle(1);
    chk("prefix_dropped", {3'b0, held}, 8'h00);
    chk("err_cleared", {7'b0, seq_err}, 8'h00);

    send_byte(8'h1D);
    idle(101);
`ifdef KEY_TRACKER_TIMEOUT_EN
    chk("timeout_release", {3'b0, held}, 8'h00);
`else
    chk("no_timeout", {3'b0, held}, 8'h01);
`endif
    send_byte(8'hF0); send_byte(8'h1D); idle(1);

    // random stream, biased towards game keys and prefixes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 99) < 65) begin
        r = $urandom_range(0, 9);
        send_byte(r == 9 ? 8'($urandom_range(0, 255)) : pool[r]);
      end else begin
        idle(1);
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
